// File: rtl/controlador_menu.sv
// Menu navigation controller: browse/confirm FSM with wrapping cursor, idle timeout and action issue.
// Latency: every button pulse or timeout takes effect in the registered outputs one cycle after sampling.
// Backpressure: SEND holds acao/acao_valid frozen until acao_ready is sampled high; buttons are ignored meanwhile.
module controlador_menu #(
  parameter  int N_OPCOES = 4,
  parameter  int TIMEOUT  = 50_000_000,
  localparam int W        = $clog2(N_OPCOES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         b_sel,
  input  logic         b_ok,
  input  logic         b_back,
  input  logic         acao_ready,
  output logic [1:0]   estado,
  output logic [W-1:0] cursor,
  output logic [W-1:0] acao,
  output logic         acao_valid
);

  // Idle counter only needs to reach TIMEOUT-1.
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    HOME = 2'd0,
    NAV  = 2'd1,
    CONF = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] idle_cnt;

  // Decoded helpers shared by NAV and CONF.
  logic          any_pulse;
  logic          idle_expired;
  logic          cursor_last;
  logic [W-1:0]  cursor_next;

  // Combinational helpers: timeout detection and wrapping cursor increment.
  always_comb begin
    any_pulse    = b_sel | b_ok | b_back;
    idle_expired = (idle_cnt == CW'(TIMEOUT - 1));
    cursor_last  = (cursor == W'(N_OPCOES - 1));
    cursor_next  = cursor_last ? '0 : cursor + W'(1);
  end

  // Single-process FSM: state, cursor, action register and idle counter all update here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HOME;
      cursor     <= '0;
      acao       <= '0;
      acao_valid <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      case (state)
        HOME: begin
          // Only select opens the menu; the cursor always restarts at the first entry.
          idle_cnt <= '0;
          if (b_sel) begin
            state  <= NAV;
            cursor <= '0;
          end
        end

        NAV: begin
          // Priority back > ok > sel; any pulse cancels a pending timeout.
          if (b_back) begin
            state    <= HOME;
            idle_cnt <= '0;
          end else if (b_ok) begin
            state    <= CONF;
            idle_cnt <= '0;
          end else if (b_sel) begin
            cursor   <= cursor_next;
            idle_cnt <= '0;
          end else if (idle_expired) begin
            state    <= HOME;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + CW'(1);
          end
        end

        CONF: begin
          // Select is ignored as a command but still counts as user activity.
          if (b_back) begin
            state    <= NAV;
            idle_cnt <= '0;
          end else if (b_ok) begin
            state      <= SEND;
            acao       <= cursor;
            acao_valid <= 1'b1;
            idle_cnt   <= '0;
          end else if (any_pulse) begin
            idle_cnt <= '0;
          end else if (idle_expired) begin
            state    <= HOME;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + CW'(1);
          end
        end

        SEND: begin
          // Hold the request until the pet-state logic takes it; no timeout here.
          idle_cnt <= '0;
          if (acao_ready) begin
            acao_valid <= 1'b0;
            state      <= HOME;
          end
        end

        default: begin
          state      <= HOME;
          acao_valid <= 1'b0;
          idle_cnt   <= '0;
        end
      endcase
    end
  end

  assign estado = state;

endmodule

// File: tb/tb_controlador_menu.sv
module tb_controlador_menu;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int W  = $clog2(N);

  logic         clk = 1'b0;
  logic         rst;
  logic         b_sel;
  logic         b_ok;
  logic         b_back;
  logic         acao_ready;
  logic [1:0]   estado;
  logic [W-1:0] cursor;
  logic [W-1:0] acao;
  logic         acao_valid;

  int errors = 0;
  int checks = 0;

  controlador_menu #(.N_OPCOES(N), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .b_sel      (b_sel),
    .b_ok       (b_ok),
    .b_back     (b_back),
    .acao_ready (acao_ready),
    .estado     (estado),
    .cursor     (cursor),
    .acao       (acao),
    .acao_valid (acao_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic o, input logic bk);
    b_sel  = s;
    b_ok   = o;
    b_back = bk;
    tick();
    b_sel  = 1'b0;
    b_ok   = 1'b0;
    b_back = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; b_sel = 1'b0; b_ok = 1'b0; b_back = 1'b0; acao_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_estado", estado, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_valid", acao_valid, 0);
    chk("rst_acao", acao, 0);

    // HOME ignores ok and back
    pulse(0, 1, 0); chk("home_ok_ign", estado, 0);
    pulse(0, 0, 1); chk("home_back_ign", estado, 0);

    // Navigate with wrap
    pulse(1, 0, 0); chk("nav_enter", estado, 1); chk("nav_cur0", cursor, 0);
    pulse(1, 0, 0); chk("nav_cur1", cursor, 1);
    pulse(1, 0, 0); chk("nav_cur2", cursor, 2);
    pulse(1, 0, 0); chk("nav_cur3", cursor, 3);
    pulse(1, 0, 0); chk("nav_wrap", cursor, 0); chk("nav_wrap_st", estado, 1);

    // Full issue
    pulse(0, 0, 1); chk("back_home", estado, 0);
    pulse(1, 0, 0); chk("iss_nav", cursor, 0);
    pulse(1, 0, 0); chk("iss_cur1", cursor, 1);
    pulse(0, 1, 0); chk("iss_conf", estado, 2);
    pulse(0, 1, 0);
    chk("iss_send", estado, 3); chk("iss_acao", acao, 1); chk("iss_valid", acao_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", acao_valid, 1);
      chk("hold_acao", acao, 1);
      chk("hold_st", estado, 3);
    end
    pulse(1, 1, 1); chk("send_btn_ign", estado, 3); chk("send_btn_valid", acao_valid, 1);
    acao_ready = 1'b1;
    tick();
    acao_ready = 1'b0;
    chk("done_valid", acao_valid, 0); chk("done_st", estado, 0);

    // Back paths
    pulse(1, 0, 0); pulse(1, 0, 0); pulse(1, 0, 0);
    chk("bp_cur2", cursor, 2);
    pulse(0, 1, 0); chk("bp_conf", estado, 2);
    pulse(0, 0, 1); chk("bp_nav", estado, 1); chk("bp_cur_keep", cursor, 2);
    pulse(0, 0, 1); chk("bp_home", estado, 0);
    pulse(1, 0, 0); chk("bp_reenter", estado, 1); chk("bp_cur_reset", cursor, 0);

    // Simultaneous pulses
    pulse(1, 0, 0); chk("sim_cur1", cursor, 1);
    pulse(1, 1, 0); chk("sim_ok_wins", estado, 2); chk("sim_cur_hold", cursor, 1);
    pulse(1, 0, 0); chk("conf_sel_ign", estado, 2); chk("conf_sel_cur", cursor, 1);
    pulse(0, 1, 1); chk("sim_back_wins", estado, 1); chk("sim_no_valid", acao_valid, 0);

    // Timeout from NAV entry at edge e
    pulse(0, 0, 1); chk("to_home0", estado, 0);
    pulse(1, 0, 0); // edge e
    for (int i = 0; i < TO - 1; i++) tick(); // edges e+1..e+15
    chk("to_still_nav", estado, 1);
    tick(); // edge e+16
    chk("to_expired", estado, 0);

    // Timeout restarted by a pulse at e+15
    pulse(1, 0, 0); // edge e
    for (int i = 0; i < TO - 2; i++) tick(); // edges e+1..e+14
    pulse(1, 0, 0); // edge e+15
    chk("to2_nav", estado, 1); chk("to2_cur", cursor, 1);
    for (int i = 0; i < TO - 1; i++) tick(); // edges e+16..e+30
    chk("to2_still_nav", estado, 1);
    tick(); // edge e+31
    chk("to2_expired", estado, 0);

    // Timeout in CONF
    pulse(1, 0, 0); pulse(0, 1, 0); // CONF entered
    for (int i = 0; i < TO - 1; i++) tick();
    chk("to_conf_hold", estado, 2);
    tick();
    chk("to_conf_exp", estado, 0);

    // Reset mid-handshake, with a coincident select pulse
    pulse(1, 0, 0); pulse(1, 0, 0); pulse(0, 1, 0); pulse(0, 1, 0);
    chk("rs_send", estado, 3); chk("rs_valid_pre", acao_valid, 1);
    rst = 1'b1; b_sel = 1'b1;
    tick();
    rst = 1'b0; b_sel = 1'b0;
    chk("rs_estado", estado, 0);
    chk("rs_valid", acao_valid, 0);
    chk("rs_cursor", cursor, 0);
    chk("rs_acao", acao, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
